bbox_tracker: RTL and testbench

- Per-frame bounding-box extractor. Consumes a 1-bit detection mask streamed alongside the pixel counters.
- Accumulates min/max x/y and a pixel count of masked pixels over one frame.
- At each frame boundary, qualifies, smooths and publishes the box. Outputs directly drive the xmin/ymin/xmax/ymax inputs of the min/max rectangle overlay sprite.
- Sits between the colour/threshold mask stage and the overlay renderer.

---
 rtl/bbox_tracker.sv | 228 ++++++++++++++++++++++
 tb/tb_bbox_tracker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bbox_tracker.sv
// Per-frame bounding-box extractor: accumulates min/max x/y and a pixel count of the
// detection mask, then qualifies, smooths and publishes the box at each frame boundary.
module bbox_tracker #(
    parameter int H_ACTIVE     = 1280,
    parameter int V_ACTIVE     = 720,
    parameter int MIN_PIXELS   = 64,
    parameter int MISS_LIMIT   = 3,
    parameter int SMOOTH_SHIFT = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        mask_in,
    input  logic        new_frame_in,
    output logic [11:0] xmin_out,
    output logic [10:0] ymin_out,
    output logic [11:0] xmax_out,
    output logic [10:0] ymax_out,
    output logic        valid_out,
    output logic        update_out,
    output logic [19:0] pixel_count_out
);

    localparam logic [11:0] H_LIM    = 12'(H_ACTIVE);
    localparam logic [10:0] V_LIM    = 11'(V_ACTIVE);
    localparam logic [11:0] X_HI     = 12'(H_ACTIVE - 1);
    localparam logic [11:0] Y_HI     = 12'(V_ACTIVE - 1);
    localparam logic [19:0] MIN_CNT  = 20'(MIN_PIXELS);
    localparam logic [7:0]  MISS_LIM = 8'(MISS_LIMIT);

    // The tracking state is visible hierarchically as `state` for checkers.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        COAST  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  miss_cnt;
    logic [7:0]  miss_cnt_nxt;

    logic [11:0] acc_xmin;
    logic [10:0] acc_ymin;
    logic [11:0] acc_xmax;
    logic [10:0] acc_ymax;
    logic [19:0] acc_count;

    logic [11:0] start_xmin;
    logic [10:0] start_ymin;
    logic [11:0] start_xmax;
    logic [10:0] start_ymax;
    logic [19:0] start_count;

    logic [11:0] hx;
    logic [10:0] vy;
    logic        qual;
    logic        hit;

    logic [11:0] xmin_nxt;
    logic [10:0] ymin_nxt;
    logic [11:0] xmax_nxt;
    logic [10:0] ymax_nxt;

    // One IIR step toward raw: diff in 13-bit signed, arithmetic shift floors toward -inf,
    // result clamped into [0, hi].
    function automatic logic [11:0] smooth(input logic [11:0] cur, input logic [11:0] raw,
                                           input logic [11:0] hi);
        logic signed [12:0] diff;
        logic signed [12:0] step;
        logic signed [13:0] sum;
        diff = $signed({1'b0, raw}) - $signed({1'b0, cur});
        step = diff >>> SMOOTH_SHIFT;
        sum  = $signed({2'b00, cur}) + $signed({step[12], step});
        if (sum[13])
            smooth = '0;
        else if (sum > $signed({2'b00, hi}))
            smooth = hi;
        else
            smooth = sum[11:0];
    endfunction

    assign hx   = {1'b0, hcount_in};
    assign vy   = {1'b0, vcount_in};
    assign qual = mask_in && (hx < H_LIM) && (vy < V_LIM);
    assign hit  = (acc_count >= MIN_CNT);

    // On a frame boundary the current pixel folds into freshly cleared accumulators.
    always_comb begin
        start_xmin  = acc_xmin;
        start_ymin  = acc_ymin;
        start_xmax  = acc_xmax;
        start_ymax  = acc_ymax;
        start_count = acc_count;
        if (new_frame_in) begin
            start_xmin  = '1;
            start_ymin  = '1;
            start_xmax  = '0;
            start_ymax  = '0;
            start_count = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            acc_xmin  <= '1;
            acc_ymin  <= '1;
            acc_xmax  <= '0;
            acc_ymax  <= '0;
            acc_count <= '0;
        end else if (qual) begin
            acc_xmin  <= (hx < start_xmin) ? hx : start_xmin;
            acc_ymin  <= (vy < start_ymin) ? vy : start_ymin;
            acc_xmax  <= (hx > start_xmax) ? hx : start_xmax;
            acc_ymax  <= (vy > start_ymax) ? vy : start_ymax;
            acc_count <= (start_count == '1) ? start_count : start_count + 20'd1;
        end else begin
            acc_xmin  <= start_xmin;
            acc_ymin  <= start_ymin;
            acc_xmax  <= start_xmax;
            acc_ymax  <= start_ymax;
            acc_count <= start_count;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state    <= SEARCH;
            miss_cnt <= '0;
        end else begin
            state    <= state_nxt;
            miss_cnt <= miss_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        miss_cnt_nxt = miss_cnt;
        if (new_frame_in) begin
            case (state)
                SEARCH: begin
                    if (hit) begin
                        state_nxt    = TRACK;
                        miss_cnt_nxt = '0;
                    end
                end
                TRACK: begin
                    if (!hit) begin
                        if (MISS_LIM <= 8'd1) begin
                            state_nxt    = SEARCH;
                            miss_cnt_nxt = '0;
                        end else begin
                            state_nxt    = COAST;
                            miss_cnt_nxt = 8'd1;
                        end
                    end
                end
                COAST: begin
                    if (hit) begin
                        state_nxt    = TRACK;
                        miss_cnt_nxt = '0;
                    end else if (miss_cnt + 8'd1 >= MISS_LIM) begin
                        state_nxt    = SEARCH;
                        miss_cnt_nxt = '0;
                    end else begin
                        miss_cnt_nxt = miss_cnt + 8'd1;
                    end
                end
                default: begin
                    state_nxt    = SEARCH;
                    miss_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Box next-value: cleared whenever the track drops, raw on acquisition, smoothed while held.
    always_comb begin
        xmin_nxt = xmin_out;
        ymin_nxt = ymin_out;
        xmax_nxt = xmax_out;
        ymax_nxt = ymax_out;
        if (new_frame_in) begin
            if (state_nxt == SEARCH) begin
                xmin_nxt = '0;
                ymin_nxt = '0;
                xmax_nxt = '0;
                ymax_nxt = '0;
            end else if (hit) begin
                if (state == SEARCH) begin
                    xmin_nxt = acc_xmin;
                    ymin_nxt = acc_ymin;
                    xmax_nxt = acc_xmax;
                    ymax_nxt = acc_ymax;
                end else begin
                    xmin_nxt = smooth(xmin_out, acc_xmin, X_HI);
                    ymin_nxt = 11'(smooth({1'b0, ymin_out}, {1'b0, acc_ymin}, Y_HI));
                    xmax_nxt = smooth(xmax_out, acc_xmax, X_HI);
                    ymax_nxt = 11'(smooth({1'b0, ymax_out}, {1'b0, acc_ymax}, Y_HI));
                end
            end
        end
    end

    // update_out strobes once per new_frame_in; valid_out qualifies the box; no backpressure.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            xmin_out        <= '0;
            ymin_out        <= '0;
            xmax_out        <= '0;
            ymax_out        <= '0;
            update_out      <= 1'b0;
            pixel_count_out <= '0;
        end else begin
            xmin_out   <= xmin_nxt;
            ymin_out   <= ymin_nxt;
            xmax_out   <= xmax_nxt;
            ymax_out   <= ymax_nxt;
            update_out <= new_frame_in;
            if (new_frame_in)
                pixel_count_out <= acc_count;
        end
    end

    assign valid_out = (state != SEARCH);

endmodule

// File: tb/tb_bbox_tracker.sv
// Randomized and directed bench for bbox_tracker against a frame-level reference model
// that keeps each frame's qualifying pixels in queues and applies the tracking rules per frame.
module tb_bbox_tracker;

    localparam int H_ACTIVE     = 1280;
    localparam int V_ACTIVE     = 720;
    localparam int MIN_PIXELS   = 64;
    localparam int MISS_LIMIT   = 3;
    localparam int SMOOTH_SHIFT = 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        mask_in = 1'b0;
    logic        new_frame_in = 1'b0;
    logic [11:0] xmin_out;
    logic [10:0] ymin_out;
    logic [11:0] xmax_out;
    logic [10:0] ymax_out;
    logic        valid_out;
    logic        update_out;
    logic [19:0] pixel_count_out;

    always #5 clk_in = ~clk_in;

    bbox_tracker #(
        .H_ACTIVE    (H_ACTIVE),
        .V_ACTIVE    (V_ACTIVE),
        .MIN_PIXELS  (MIN_PIXELS),
        .MISS_LIMIT  (MISS_LIMIT),
        .SMOOTH_SHIFT(SMOOTH_SHIFT)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .mask_in        (mask_in),
        .new_frame_in   (new_frame_in),
        .xmin_out       (xmin_out),
        .ymin_out       (ymin_out),
        .xmax_out       (xmax_out),
        .ymax_out       (ymax_out),
        .valid_out      (valid_out),
        .update_out     (update_out),
        .pixel_count_out(pixel_count_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: pixels of the open frame, plus the published view.
    int px_x[$];
    int px_y[$];
    int m_box[4];
    int m_valid;
    int m_miss;
    int m_count;
    int m_update;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (rst_in && valid_out) begin
            box_order: assert (xmin_out <= xmax_out && ymin_out <= ymax_out)
                else $error("FAIL box_order x=%0d..%0d y=%0d..%0d", xmin_out, xmax_out,
                            ymin_out, ymax_out);
        end
    end

    function automatic int floor_div(input int a, input int d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic int smooth_ref(input int cur, input int raw, input int hi);
        int n;
        n = cur + floor_div(raw - cur, 1 << SMOOTH_SHIFT);
        if (n < 0) n = 0;
        if (n > hi) n = hi;
        return n;
    endfunction

    task automatic model_reset();
        px_x.delete();
        px_y.delete();
        for (int i = 0; i < 4; i++) m_box[i] = 0;
        m_valid  = 0;
        m_miss   = 0;
        m_count  = 0;
        m_update = 0;
    endtask

    task automatic model_close();
        int cnt;
        int r[4];
        cnt  = px_x.size();
        r[0] = H_ACTIVE; r[1] = V_ACTIVE; r[2] = 0; r[3] = 0;
        for (int i = 0; i < cnt; i++) begin
            if (px_x[i] < r[0]) r[0] = px_x[i];
            if (px_y[i] < r[1]) r[1] = px_y[i];
            if (px_x[i] > r[2]) r[2] = px_x[i];
            if (px_y[i] > r[3]) r[3] = px_y[i];
        end
        if (cnt >= MIN_PIXELS) begin
            if (m_valid == 0) begin
                m_box   = r;
                m_valid = 1;
            end else begin
                m_box[0] = smooth_ref(m_box[0], r[0], H_ACTIVE - 1);
                m_box[1] = smooth_ref(m_box[1], r[1], V_ACTIVE - 1);
                m_box[2] = smooth_ref(m_box[2], r[2], H_ACTIVE - 1);
                m_box[3] = smooth_ref(m_box[3], r[3], V_ACTIVE - 1);
            end
            m_miss = 0;
        end else if (m_valid != 0) begin
            m_miss++;
            if (m_miss >= MISS_LIMIT) begin
                m_valid = 0;
                m_miss  = 0;
                for (int i = 0; i < 4; i++) m_box[i] = 0;
            end
        end
        m_count = cnt;
        px_x.delete();
        px_y.delete();
    endtask

    task automatic check_all();
        check("update", update_out, m_update);
        check("valid", valid_out, m_valid);
        check("xmin", xmin_out, m_box[0]);
        check("ymin", ymin_out, m_box[1]);
        check("xmax", xmax_out, m_box[2]);
        check("ymax", ymax_out, m_box[3]);
        check("count", pixel_count_out, m_count);
    endtask

    // One pixel-clock cycle: drive, advance the model, check after the edge settles.
    task automatic cycle(input int h, input int v, input bit m, input bit nf);
        @(negedge clk_in);
        hcount_in    = h[10:0];
        vcount_in    = v[9:0];
        mask_in      = m;
        new_frame_in = nf;
        m_update     = nf;
        if (nf) model_close();
        if (m && h < H_ACTIVE && v < V_ACTIVE) begin
            px_x.push_back(h);
            px_y.push_back(v);
        end
        @(posedge clk_in);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in       = 1'b0;
        mask_in      = 1'b0;
        new_frame_in = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic expect_box(input string tag, input int x0, input int y0, input int x1,
                              input int y1, input int vld, input int cnt);
        check({tag, "_valid"}, valid_out, vld);
        check({tag, "_xmin"}, xmin_out, x0);
        check({tag, "_ymin"}, ymin_out, y0);
        check({tag, "_xmax"}, xmax_out, x1);
        check({tag, "_ymax"}, ymax_out, y1);
        check({tag, "_count"}, pixel_count_out, cnt);
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge clk_in);
        rst_in = 1'b1;

        // Acquisition: raw load of a 10x10 block.
        for (int y = 50; y < 60; y++)
            for (int x = 200; x < 210; x++) cycle(x, y, 1'b1, 1'b0);
        cycle(0, 0, 1'b0, 1'b1);
        check("tp1_update", update_out, 1);
        expect_box("tp1", 200, 50, 209, 59, 1, 100);

        // Same block shifted right by 40: edges move a quarter of the way.
        for (int y = 50; y < 60; y++)
            for (int x = 240; x < 250; x++) cycle(x, y, 1'b1, 1'b0);
        cycle(0, 0, 1'b0, 1'b1);
        expect_box("tp2", 210, 50, 219, 59, 1, 100);

        // One short of the hit threshold, then two empty frames drop the track.
        for (int i = 0; i < 63; i++) cycle(240 + i % 10, 50 + i / 10, 1'b1, 1'b0);
        cycle(0, 0, 1'b0, 1'b1);
        check("tp3_update", update_out, 1);
        expect_box("tp3", 210, 50, 219, 59, 1, 63);
        repeat (5) cycle(0, 0, 1'b0, 1'b0);
        cycle(0, 0, 1'b0, 1'b1);
        check("tp3_coast_valid", valid_out, 1);
        repeat (5) cycle(0, 0, 1'b0, 1'b0);
        cycle(0, 0, 1'b0, 1'b1);
        expect_box("tp3_drop", 0, 0, 0, 0, 0, 0);

        // Out-of-window pixels are ignored.
        for (int i = 0; i < 80; i++) cycle(1300, 10, 1'b1, 1'b0);
        for (int i = 0; i < 80; i++) cycle(10, 730, 1'b1, 1'b0);
        cycle(0, 0, 1'b0, 1'b1);
        expect_box("tp4", 0, 0, 0, 0, 0, 0);

        // Pixel coincident with the frame boundary belongs to the new frame.
        cycle(5, 5, 1'b1, 1'b1);
        for (int x = 20; x <= 82; x++) cycle(x, 5, 1'b1, 1'b0);
        cycle(0, 0, 1'b0, 1'b1);
        expect_box("tp5", 5, 5, 82, 5, 1, 64);

        // Back-to-back boundaries: the second frame is a miss, both pulses seen.
        for (int i = 0; i < 80; i++) cycle(30 + i % 20, 8 + i / 20, 1'b1, 1'b0);
        cycle(0, 0, 1'b0, 1'b1);
        cycle(7, 7, 1'b1, 1'b1);
        check("b2b_update", update_out, 1);
        check("b2b_count", pixel_count_out, 0);
        cycle(0, 0, 1'b0, 1'b1);
        check("b2b_count1", pixel_count_out, 1);

        // Reset mid-frame discards accumulation.
        for (int i = 0; i < 500; i++)
            cycle($urandom_range(0, 1279), $urandom_range(0, 719), 1'b1, 1'b0);
        do_reset();
        for (int x = 400; x < 470; x++) cycle(x, 300, 1'b1, 1'b0);
        cycle(0, 0, 1'b0, 1'b1);
        expect_box("tp6", 400, 300, 469, 300, 1, 70);

        // Randomized frames straddling the hit threshold, with stray and off-window pixels.
        for (int f = 0; f < 40; f++) begin
            int kind, x0, y0, w, hh, np;
            kind = $urandom_range(0, 9);
            x0   = $urandom_range(0, 1200);
            y0   = $urandom_range(0, 700);
            w    = $urandom_range(1, 79);
            hh   = $urandom_range(1, 19);
            np   = (kind < 2) ? $urandom_range(0, 10) : $urandom_range(40, 140);
            for (int p = 0; p < np; p++) begin
                int px, py, r;
                px = x0 + $urandom_range(0, w);
                py = y0 + $urandom_range(0, hh);
                r  = $urandom_range(0, 15);
                if (r == 0) px = $urandom_range(1280, 2047);
                if (r == 1) py = $urandom_range(720, 1023);
                cycle(px, py, r != 2, 1'b0);
            end
            cycle(x0, y0, $urandom_range(0, 3) == 0, 1'b1);
            if (kind == 9) cycle(0, 0, 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
